gba_line_cache: RTL and testbench

Four-line ring buffer between the GBA capture front-end and the HDMI image generator. It stores GBA pixels as they arrive, one 24-bit RGB word per pixel. It serves the image generator's read requests (`curPxl`, `nextLine`, `cacheUpdate`) with the 3x3 neighbourhood around the requested pixel, which feeds the grid and smoothing paths. It also flow-controls line advance with `sameLine` and signals frame start with `newFrameOut`.

---
 rtl/gba_line_cache.sv | 246 ++++++++++++++++++++++++
 tb/tb_gba_line_cache.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gba_line_cache.sv
// rtl/gba_line_cache.sv - four-line ring buffer serving a 3x3 pixel neighbourhood
//
// Purpose: buffers GBA pixels (24-bit RGB) into four line buffers and serves the
// HDMI image generator with the 3x3 neighbourhood around the requested pixel.
// Also paces the reader (sameLine), flags frame start (newFrameOut), and latches
// writer/reader collisions (overflow).
//
// Ports:
//   pxlClk, rstN                single clock, asynchronous active-low reset
//   wrValid, wrRed/Green/Blue   one captured pixel per cycle
//   wrFrameStart                next wrValid is pixel 0 of line 0
//   curPxl, nextLine            read pixel index / advance read line
//   cacheUpdate                 end of output line, read-side resync point
//   *Line*Pxl*Out               3x3 neighbourhood, 2-cycle latency from curPxl
//   sameLine                    read line may not advance yet
//   newFrameOut                 one-cycle pulse, new frame ready to read
//   overflow                    sticky writer/reader collision flag
module gba_line_cache #(
  parameter int LINE_WIDTH  = 240,
  parameter int FRAME_LINES = 160
) (
  input  logic       pxlClk,
  input  logic       rstN,
  input  logic       wrValid,
  input  logic [7:0] wrRed,
  input  logic [7:0] wrGreen,
  input  logic [7:0] wrBlue,
  input  logic       wrFrameStart,
  input  logic [7:0] curPxl,
  input  logic       nextLine,
  input  logic       cacheUpdate,
  output logic [7:0] prevLinePrevPxlRedOut,
  output logic [7:0] prevLinePrevPxlGreenOut,
  output logic [7:0] prevLinePrevPxlBlueOut,
  output logic [7:0] prevLineCurPxlRedOut,
  output logic [7:0] prevLineCurPxlGreenOut,
  output logic [7:0] prevLineCurPxlBlueOut,
  output logic [7:0] prevLineNextPxlRedOut,
  output logic [7:0] prevLineNextPxlGreenOut,
  output logic [7:0] prevLineNextPxlBlueOut,
  output logic [7:0] curLinePrevPxlRedOut,
  output logic [7:0] curLinePrevPxlGreenOut,
  output logic [7:0] curLinePrevPxlBlueOut,
  output logic [7:0] curLineCurPxlRedOut,
  output logic [7:0] curLineCurPxlGreenOut,
  output logic [7:0] curLineCurPxlBlueOut,
  output logic [7:0] curLineNextPxlRedOut,
  output logic [7:0] curLineNextPxlGreenOut,
  output logic [7:0] curLineNextPxlBlueOut,
  output logic [7:0] nextLinePrevPxlRedOut,
  output logic [7:0] nextLinePrevPxlGreenOut,
  output logic [7:0] nextLinePrevPxlBlueOut,
  output logic [7:0] nextLineCurPxlRedOut,
  output logic [7:0] nextLineCurPxlGreenOut,
  output logic [7:0] nextLineCurPxlBlueOut,
  output logic [7:0] nextLineNextPxlRedOut,
  output logic [7:0] nextLineNextPxlGreenOut,
  output logic [7:0] nextLineNextPxlBlueOut,
  output logic       sameLine,
  output logic       newFrameOut,
  output logic       overflow
);

  localparam logic [7:0] LastPxl     = 8'(LINE_WIDTH - 1);
  localparam logic [7:0] FrameLines  = 8'(FRAME_LINES);
  localparam logic [7:0] LastLine    = 8'(FRAME_LINES - 1);
  localparam logic [8:0] FrameLines9 = 9'(FRAME_LINES);

  logic [23:0] mem_q [4][LINE_WIDTH];

  logic [1:0] wr_buf_q, wr_buf_d;
  logic [7:0] wr_pxl_q, wr_pxl_d;
  logic [7:0] wr_line_q, wr_line_d;
  logic       frame_pending_q, frame_pending_d;
  logic [1:0] rd_buf_q, rd_buf_d;
  logic [7:0] rd_line_q, rd_line_d;
  logic       rd_resync_q, rd_resync_d;
  logic       new_frame_q, new_frame_d;
  logic       same_line_q, same_line_d;
  logic       overflow_q, overflow_d;

  // Stage 1: selected buffers/pixels, index 0=prev 1=cur 2=next
  logic [2:0][1:0]       s1_buf_q;
  logic [2:0][7:0]       s1_pxl_q;
  // Stage 2: neighbourhood, [line][pixel]
  logic [2:0][2:0][23:0] nb_q, nb_d;

  logic [1:0] wr_buf_eff;
  logic [7:0] wr_pxl_eff, wr_line_eff;
  logic       wr_en, line_done, frame_ready;
  logic [1:0] prev_buf, next_buf;
  logic [7:0] cur_px, prev_px, next_px;
  logic [8:0] same_lim;

  // Write side: a frame start in the same cycle as a pixel takes effect first.
  always_comb begin
    wr_buf_eff  = wrFrameStart ? 2'd0 : wr_buf_q;
    wr_pxl_eff  = wrFrameStart ? 8'd0 : wr_pxl_q;
    wr_line_eff = wrFrameStart ? 8'd0 : wr_line_q;
    wr_en       = wrValid && (wr_line_eff != FrameLines);
    line_done   = wr_en && (wr_pxl_eff == LastPxl);
    wr_buf_d    = wr_buf_eff;
    wr_pxl_d    = wr_pxl_eff;
    wr_line_d   = wr_line_eff;
    if (wr_en) begin
      if (line_done) begin
        wr_pxl_d  = 8'd0;
        wr_buf_d  = wr_buf_eff + 2'd1;
        wr_line_d = wr_line_eff + 8'd1;
      end else begin
        wr_pxl_d  = wr_pxl_eff + 8'd1;
      end
    end
    // Lines 0 and 1 complete: enough of the frame exists to start reading.
    frame_ready     = line_done && (wr_line_eff == 8'd1) && frame_pending_q;
    new_frame_d     = frame_ready;
    frame_pending_d = frame_ready ? 1'b0 : (wrFrameStart | frame_pending_q);
  end

  // Neighbour selection with top/bottom line and left/right pixel clamping.
  always_comb begin
    prev_buf = (rd_line_q == 8'd0)     ? rd_buf_q : rd_buf_q - 2'd1;
    next_buf = (rd_line_q == LastLine) ? rd_buf_q : rd_buf_q + 2'd1;
    cur_px   = (curPxl > LastPxl) ? LastPxl : curPxl;
    prev_px  = (cur_px == 8'd0)    ? 8'd0   : cur_px - 8'd1;
    next_px  = (cur_px == LastPxl) ? cur_px : cur_px + 8'd1;
  end

  // Read side: a pending resync wins over a simultaneous nextLine.
  always_comb begin
    rd_buf_d    = rd_buf_q;
    rd_line_d   = rd_line_q;
    rd_resync_d = rd_resync_q;
    if (cacheUpdate && rd_resync_q) begin
      rd_buf_d    = 2'd0;  // line 0 of a frame always lands in buffer 0
      rd_line_d   = 8'd0;
      rd_resync_d = 1'b0;
    end else if (nextLine && (rd_line_q < LastLine)) begin
      rd_buf_d    = rd_buf_q + 2'd1;
      rd_line_d   = rd_line_q + 8'd1;
    end
    if (frame_ready) begin
      rd_resync_d = 1'b1;
    end
  end

  // The writer starting line rd+2 uses the spare fourth buffer; starting any
  // later line on a buffer of the read set would overwrite a line still in use.
  always_comb begin
    overflow_d = overflow_q;
    if (line_done && (wr_line_eff != LastLine) &&
        ((wr_buf_d == prev_buf) || (wr_buf_d == rd_buf_q) || (wr_buf_d == next_buf)) &&
        ({1'b0, wr_line_d} > ({1'b0, rd_line_q} + 9'd1))) begin
      overflow_d = 1'b1;
    end
  end

  // Hold the reader until the line that would become "next" has been written.
  always_comb begin
    same_lim = {1'b0, rd_line_q} + 9'd3;
    if (same_lim > FrameLines9) begin
      same_lim = FrameLines9;
    end
    same_line_d = ({1'b0, wr_line_q} < same_lim);
  end

  always_comb begin
    nb_d = '0;
    for (int l = 0; l < 3; l++) begin
      for (int p = 0; p < 3; p++) begin
        nb_d[l][p] = mem_q[s1_buf_q[l]][s1_pxl_q[p]];
      end
    end
  end

  always_ff @(posedge pxlClk) begin
    if (wr_en) begin
      mem_q[wr_buf_eff][wr_pxl_eff] <= {wrRed, wrGreen, wrBlue};
    end
  end

  always_ff @(posedge pxlClk or negedge rstN) begin
    if (!rstN) begin
      wr_buf_q        <= 2'd0;
      wr_pxl_q        <= 8'd0;
      wr_line_q       <= 8'd0;
      frame_pending_q <= 1'b0;
      rd_buf_q        <= 2'd0;
      rd_line_q       <= 8'd0;
      rd_resync_q     <= 1'b0;
      new_frame_q     <= 1'b0;
      same_line_q     <= 1'b1;
      overflow_q      <= 1'b0;
      s1_buf_q        <= '0;
      s1_pxl_q        <= '0;
      nb_q            <= '0;
    end else begin
      wr_buf_q        <= wr_buf_d;
      wr_pxl_q        <= wr_pxl_d;
      wr_line_q       <= wr_line_d;
      frame_pending_q <= frame_pending_d;
      rd_buf_q        <= rd_buf_d;
      rd_line_q       <= rd_line_d;
      rd_resync_q     <= rd_resync_d;
      new_frame_q     <= new_frame_d;
      same_line_q     <= same_line_d;
      overflow_q      <= overflow_d;
      s1_buf_q        <= {next_buf, rd_buf_q, prev_buf};
      s1_pxl_q        <= {next_px, cur_px, prev_px};
      nb_q            <= nb_d;
    end
  end

  assign sameLine    = same_line_q;
  assign newFrameOut = new_frame_q;
  assign overflow    = overflow_q;

  assign prevLinePrevPxlRedOut   = nb_q[0][0][23:16];
  assign prevLinePrevPxlGreenOut = nb_q[0][0][15:8];
  assign prevLinePrevPxlBlueOut  = nb_q[0][0][7:0];
  assign prevLineCurPxlRedOut    = nb_q[0][1][23:16];
  assign prevLineCurPxlGreenOut  = nb_q[0][1][15:8];
  assign prevLineCurPxlBlueOut   = nb_q[0][1][7:0];
  assign prevLineNextPxlRedOut   = nb_q[0][2][23:16];
  assign prevLineNextPxlGreenOut = nb_q[0][2][15:8];
  assign prevLineNextPxlBlueOut  = nb_q[0][2][7:0];
  assign curLinePrevPxlRedOut    = nb_q[1][0][23:16];
  assign curLinePrevPxlGreenOut  = nb_q[1][0][15:8];
  assign curLinePrevPxlBlueOut   = nb_q[1][0][7:0];
  assign curLineCurPxlRedOut     = nb_q[1][1][23:16];
  assign curLineCurPxlGreenOut   = nb_q[1][1][15:8];
  assign curLineCurPxlBlueOut    = nb_q[1][1][7:0];
  assign curLineNextPxlRedOut    = nb_q[1][2][23:16];
  assign curLineNextPxlGreenOut  = nb_q[1][2][15:8];
  assign curLineNextPxlBlueOut   = nb_q[1][2][7:0];
  assign nextLinePrevPxlRedOut   = nb_q[2][0][23:16];
  assign nextLinePrevPxlGreenOut = nb_q[2][0][15:8];
  assign nextLinePrevPxlBlueOut  = nb_q[2][0][7:0];
  assign nextLineCurPxlRedOut    = nb_q[2][1][23:16];
  assign nextLineCurPxlGreenOut  = nb_q[2][1][15:8];
  assign nextLineCurPxlBlueOut   = nb_q[2][1][7:0];
  assign nextLineNextPxlRedOut   = nb_q[2][2][23:16];
  assign nextLineNextPxlGreenOut = nb_q[2][2][15:8];
  assign nextLineNextPxlBlueOut  = nb_q[2][2][7:0];

endmodule

// File: tb/tb_gba_line_cache.sv
// tb/tb_gba_line_cache.sv - scoreboard bench for gba_line_cache
module tb_gba_line_cache;

  logic       pxlClk = 1'b0;
  logic       rstN;
  logic       wrValid, wrFrameStart, nextLine, cacheUpdate;
  logic [7:0] wrRed, wrGreen, wrBlue, curPxl;
  logic [7:0] o_pp_r, o_pp_g, o_pp_b, o_pc_r, o_pc_g, o_pc_b, o_pn_r, o_pn_g, o_pn_b;
  logic [7:0] o_cp_r, o_cp_g, o_cp_b, o_cc_r, o_cc_g, o_cc_b, o_cn_r, o_cn_g, o_cn_b;
  logic [7:0] o_np_r, o_np_g, o_np_b, o_nc_r, o_nc_g, o_nc_b, o_nn_r, o_nn_g, o_nn_b;
  logic       sameLine, newFrameOut, overflow;

  gba_line_cache dut (
    .pxlClk(pxlClk), .rstN(rstN), .wrValid(wrValid),
    .wrRed(wrRed), .wrGreen(wrGreen), .wrBlue(wrBlue),
    .wrFrameStart(wrFrameStart), .curPxl(curPxl), .nextLine(nextLine),
    .cacheUpdate(cacheUpdate),
    .prevLinePrevPxlRedOut(o_pp_r), .prevLinePrevPxlGreenOut(o_pp_g), .prevLinePrevPxlBlueOut(o_pp_b),
    .prevLineCurPxlRedOut(o_pc_r), .prevLineCurPxlGreenOut(o_pc_g), .prevLineCurPxlBlueOut(o_pc_b),
    .prevLineNextPxlRedOut(o_pn_r), .prevLineNextPxlGreenOut(o_pn_g), .prevLineNextPxlBlueOut(o_pn_b),
    .curLinePrevPxlRedOut(o_cp_r), .curLinePrevPxlGreenOut(o_cp_g), .curLinePrevPxlBlueOut(o_cp_b),
    .curLineCurPxlRedOut(o_cc_r), .curLineCurPxlGreenOut(o_cc_g), .curLineCurPxlBlueOut(o_cc_b),
    .curLineNextPxlRedOut(o_cn_r), .curLineNextPxlGreenOut(o_cn_g), .curLineNextPxlBlueOut(o_cn_b),
    .nextLinePrevPxlRedOut(o_np_r), .nextLinePrevPxlGreenOut(o_np_g), .nextLinePrevPxlBlueOut(o_np_b),
    .nextLineCurPxlRedOut(o_nc_r), .nextLineCurPxlGreenOut(o_nc_g), .nextLineCurPxlBlueOut(o_nc_b),
    .nextLineNextPxlRedOut(o_nn_r), .nextLineNextPxlGreenOut(o_nn_g), .nextLineNextPxlBlueOut(o_nn_b),
    .sameLine(sameLine), .newFrameOut(newFrameOut), .overflow(overflow)
  );

  always #5 pxlClk = ~pxlClk;

  int cyc = 0;
  always @(posedge pxlClk) cyc <= cyc + 1;

  logic [215:0] nb_act;
  assign nb_act = {o_pp_r, o_pp_g, o_pp_b, o_pc_r, o_pc_g, o_pc_b, o_pn_r, o_pn_g, o_pn_b,
                   o_cp_r, o_cp_g, o_cp_b, o_cc_r, o_cc_g, o_cc_b, o_cn_r, o_cn_g, o_cn_b,
                   o_np_r, o_np_g, o_np_b, o_nc_r, o_nc_g, o_nc_b, o_nn_r, o_nn_g, o_nn_b};

  // kind: 0 neighbourhood, 1 sameLine, 2 newFrameOut, 3 overflow, 4 newFrame pulse count
  typedef struct {
    int           kind;
    logic [215:0] exp;
    int           due;
  } item_t;

  item_t sb[$];
  int n_cmp  = 0;
  int n_bad  = 0;
  int nf_cnt = 0;

  function automatic logic [23:0] pix(input logic [7:0] tag, input int line, input int x);
    return {8'(x), 8'(line), tag};
  endfunction

  function automatic logic [215:0] nbhd(input logic [7:0] tag, input int r, input int c);
    int lines [3];
    int pxs [3];
    int cc;
    logic [215:0] v;
    cc = (c > 239) ? 239 : c;
    lines[0] = (r == 0) ? 0 : r - 1;
    lines[1] = r;
    lines[2] = (r == 159) ? 159 : r + 1;
    pxs[0] = (cc == 0) ? 0 : cc - 1;
    pxs[1] = cc;
    pxs[2] = (cc == 239) ? 239 : cc + 1;
    v = '0;
    for (int l = 0; l < 3; l++)
      for (int p = 0; p < 3; p++)
        v = {v[191:0], pix(tag, lines[l], pxs[p])};
    return v;
  endfunction

  always @(negedge pxlClk) begin : monitor
    logic [215:0] act;
    string nm;
    if (rstN && newFrameOut) nf_cnt++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        case (sb[i].kind)
          0: begin act = nb_act;               nm = "nbhd";        end
          1: begin act = 216'(sameLine);       nm = "sameLine";    end
          2: begin act = 216'(newFrameOut);    nm = "newFrameOut"; end
          3: begin act = 216'(overflow);       nm = "overflow";    end
          default: begin act = 216'(nf_cnt);   nm = "newFrameCnt"; end
        endcase
        n_cmp++;
        if (sb[i].due < cyc) begin
          n_bad++;
          $display("FAIL %s slot %0d missed at cycle %0d", nm, sb[i].due, cyc);
        end else if (act !== sb[i].exp) begin
          n_bad++;
          $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge pxlClk);
    #1;
  endtask

  task automatic push(input int kind, input logic [215:0] exp, input int due);
    item_t it;
    it.kind = kind;
    it.exp  = exp;
    it.due  = due;
    sb.push_back(it);
  endtask

  task automatic write_line(input logic [7:0] tag, input int line, input int n,
                            input bit fs_first, output int last_k);
    last_k = cyc;
    for (int x = 0; x < n; x++) begin
      wrValid      = 1'b1;
      wrFrameStart = fs_first && (x == 0);
      wrRed        = 8'(x);
      wrGreen      = 8'(line);
      wrBlue       = tag;
      last_k       = cyc;
      step();
    end
    wrValid      = 1'b0;
    wrFrameStart = 1'b0;
  endtask

  task automatic frame_start();
    wrFrameStart = 1'b1;
    step();
    wrFrameStart = 1'b0;
  endtask

  task automatic cache_update();
    cacheUpdate = 1'b1;
    step();
    cacheUpdate = 1'b0;
  endtask

  task automatic next_line(input int n);
    nextLine = 1'b1;
    repeat (n) step();
    nextLine = 1'b0;
  endtask

  task automatic read_px(input logic [7:0] tag, input int r, input int c);
    curPxl = 8'(c);
    push(0, nbhd(tag, r, c), cyc + 2);
    step();
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    step();
    step();
    rstN = 1'b1;
    step();
  endtask

  initial begin : main
    int k;
    rstN = 1'b0; wrValid = 1'b0; wrFrameStart = 1'b0; nextLine = 1'b0;
    cacheUpdate = 1'b0; wrRed = 8'd0; wrGreen = 8'd0; wrBlue = 8'd0; curPxl = 8'd0;
    step();
    step();

    // Reset state, then idle
    push(0, '0, cyc); push(1, 216'(1), cyc); push(2, '0, cyc); push(3, '0, cyc);
    step();
    rstN = 1'b1;
    repeat (20) step();
    push(4, 216'(0), cyc); push(1, 216'(1), cyc);
    step();

    // Lines 0 and 1, frame pulse, first reads at line 0
    frame_start();
    write_line(8'h5A, 0, 240, 1'b0, k);
    write_line(8'h5A, 1, 240, 1'b0, k);
    push(2, 216'(1), k + 1);
    push(2, 216'(0), k + 2);
    push(1, 216'(1), k + 2);
    step(); step();
    push(4, 216'(1), cyc);
    cache_update();
    read_px(8'h5A, 0, 5);
    read_px(8'h5A, 0, 0);
    read_px(8'h5A, 0, 239);
    read_px(8'h5A, 0, 250);
    repeat (3) step();

    // sameLine pacing
    write_line(8'h5A, 2, 240, 1'b0, k);
    repeat (3) step();
    push(1, 216'(0), cyc);
    step();
    next_line(1);
    repeat (3) step();
    push(1, 216'(1), cyc);
    step();
    write_line(8'h5A, 3, 240, 1'b0, k);
    push(1, 216'(1), k + 1);
    push(1, 216'(0), k + 2);
    read_px(8'h5A, 1, 7);
    read_px(8'h5A, 1, 0);
    repeat (3) step();

    // Overflow with stalled reader, then mid-frame restart
    do_reset();
    frame_start();
    for (int l = 0; l < 4; l++) write_line(8'h5A, l, 240, 1'b0, k);
    cache_update();
    repeat (2) step();
    push(3, 216'(1), cyc);
    step();
    next_line(2);
    write_line(8'h5A, 4, 10, 1'b0, k);
    write_line(8'hA5, 0, 240, 1'b1, k);
    cache_update();
    read_px(8'h5A, 2, 3);
    repeat (3) step();
    push(3, 216'(1), cyc);
    step();
    write_line(8'hA5, 1, 240, 1'b0, k);
    push(2, 216'(1), k + 1);
    repeat (3) step();
    cache_update();
    read_px(8'hA5, 0, 3);
    read_px(8'hA5, 0, 239);
    repeat (3) step();
    push(3, 216'(1), cyc);
    step();

    // Full frame, reader parked at the last line
    do_reset();
    write_line(8'h5A, 0, 240, 1'b1, k);
    for (int l = 1; l < 160; l++) write_line(8'h5A, l, 240, 1'b0, k);
    cache_update();
    next_line(159);
    read_px(8'h5A, 159, 100);
    repeat (3) step();
    push(1, 216'(0), cyc);
    step();
    next_line(1);
    read_px(8'h5A, 159, 239);
    read_px(8'h5A, 159, 0);
    repeat (3) step();
    push(4, 216'(4), cyc);
    step();
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
